// File: rtl/imem_program_loader.sv
// Boot-time instruction memory loader: packs a byte stream into 32-bit words,
// writes them from address 0 upward and holds the core in reset until loading finishes.
module imem_program_loader #(
  parameter int INST_WIDTH     = 32,
  parameter int INST_ADD_WIDTH = 32,
  parameter int INST_MEM_DEPTH = 100,
  parameter int CNT_WIDTH      = 7
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Load_Start,
  input  logic [CNT_WIDTH-1:0]      Load_Words,
  input  logic                      Byte_Valid,
  input  logic [7:0]                Byte_Data,
  output logic                      Byte_Ready,
  output logic                      Wr_En,
  output logic [INST_ADD_WIDTH-1:0] Wr_Add,
  output logic [INST_WIDTH-1:0]     Wr_Data,
  output logic                      Core_Hold,
  output logic                      Load_Done,
  output logic                      Load_Err
);

  // state | meaning
  // IDLE  | after reset, waiting for Load_Start
  // RECV  | accepting bytes of the current word
  // WRITE | one-cycle write of the assembled word
  // DONE  | program loaded, core released
  // ERR   | requested length larger than the memory
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    word_idx;
  logic [CNT_WIDTH-1:0]    len;
  logic [1:0]              byte_idx;
  logic [INST_WIDTH-1:0]   shift_q;
  logic                    start_ok;
  logic                    byte_hs;
  logic                    last_word;

  assign start_ok  = Load_Start && (state == IDLE || state == DONE || state == ERR);
  assign byte_hs   = (state == RECV) && Byte_Valid;
  assign last_word = (word_idx + CNT_WIDTH'(1)) == len;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (Load_Start) begin
          if (Load_Words == '0)                                 state_nxt = DONE;
          else if (Load_Words > CNT_WIDTH'(INST_MEM_DEPTH))     state_nxt = ERR;
          else                                                  state_nxt = RECV;
        end
      end
      RECV:    if (byte_hs && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : RECV;
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes shift in from the LSB end, so the first byte of a word ends up as its MSB.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      word_idx <= '0;
      len      <= '0;
      byte_idx <= '0;
      shift_q  <= '0;
    end else begin
      if (start_ok) begin
        len      <= Load_Words;
        word_idx <= '0;
        byte_idx <= '0;
        shift_q  <= '0;
      end
      if (byte_hs) begin
        shift_q  <= {shift_q[INST_WIDTH-9:0], Byte_Data};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE) word_idx <= word_idx + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    Byte_Ready = (state == RECV);
    Wr_En      = (state == WRITE);
    Wr_Add     = '0;
    Wr_Data    = '0;
    if (state == WRITE) begin
      Wr_Add  = {{(INST_ADD_WIDTH-CNT_WIDTH-2){1'b0}}, word_idx, 2'b00};
      Wr_Data = shift_q;
    end
    Core_Hold  = (state != DONE);
    Load_Done  = (state == DONE);
    Load_Err   = (state == ERR);
  end

endmodule
